// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB configuration sequencer: FSM encoding,
// table marker constants and width helpers.
package sccb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DELAY,
    S_DONE,
    S_FAIL
  } sccb_state_e;

  // Marker constants are all-ones at any width; users truncate with an explicit cast.
  localparam logic [31:0] SCCB_MARK_ADDR = 32'hFFFF_FFFF;
  localparam logic [31:0] SCCB_END_VALUE = 32'hFFFF_FFFF;

  // Bit width able to hold values 0..n-1, never below one bit.
  function automatic int unsigned sccb_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit width of a counter holding (2**data_w - 1) * unit without overflow.
  function automatic int unsigned sccb_cnt_width(input int unsigned data_w,
                                                 input int unsigned unit);
    longint unsigned max_v;
    max_v = ((longint'(1) << data_w) - 1) * longint'(unit);
    return (max_v > 0) ? $clog2(max_v + 1) : 1;
  endfunction

endpackage

// File: rtl/sccb_config_seq_if.sv
// Write-request handshake between the config sequencer and an SCCB master.
interface sccb_config_seq_if #(
  parameter int unsigned P_ADDR_W = 8,
  parameter int unsigned P_DATA_W = 8
);
  logic                SCCB_fReady;
  logic                SCCB_fNack;
  logic                SCCB_fStart;
  logic [P_ADDR_W-1:0] SCCB_Address;
  logic [P_DATA_W-1:0] SCCB_Value;

  modport master (
    input  SCCB_fReady,
    input  SCCB_fNack,
    output SCCB_fStart,
    output SCCB_Address,
    output SCCB_Value
  );

  modport slave (
    output SCCB_fReady,
    output SCCB_fNack,
    input  SCCB_fStart,
    input  SCCB_Address,
    input  SCCB_Value
  );
endinterface

// File: rtl/sccb_config_rom.sv
// Register table: synchronous read, one-cycle latency, entry i holds
// {address, value} at bits [i*ENTRY_W +: ENTRY_W] of P_ROM_DATA.
module sccb_config_rom
  import sccb_pkg::*;
#(
  parameter int unsigned P_NUM_REGS = 76,
  parameter int unsigned P_ADDR_W   = 8,
  parameter int unsigned P_DATA_W   = 8,
  parameter logic [P_NUM_REGS*(P_ADDR_W+P_DATA_W)-1:0] P_ROM_DATA = '1,
  localparam int unsigned IDX_W   = sccb_idx_width(P_NUM_REGS),
  localparam int unsigned ENTRY_W = P_ADDR_W + P_DATA_W
) (
  input  logic               i_Clk,
  input  logic [IDX_W-1:0]   i_Idx,
  output logic [ENTRY_W-1:0] o_Entry
);

  logic [ENTRY_W-1:0] table_c [P_NUM_REGS];
  logic [ENTRY_W-1:0] rd_q;

  // Unpack the flat table parameter into addressable entries.
  for (genvar g = 0; g < int'(P_NUM_REGS); g++) begin : g_tbl
    assign table_c[g] = P_ROM_DATA[g*ENTRY_W +: ENTRY_W];
  end

  // Memory-style registered read; no reset so it maps onto ROM macros.
  always_ff @(posedge i_Clk) begin
    rd_q <= table_c[i_Idx];
  end

  assign o_Entry = rd_q;

endmodule

// File: rtl/sccb_config_seq.sv
// Walks a register table after reset and issues SCCB writes, handling delay
// entries, an end marker, NACK retries and a sticky done/error status.
module sccb_config_seq
  import sccb_pkg::*;
#(
  parameter int unsigned P_NUM_REGS   = 76,
  parameter int unsigned P_ADDR_W     = 8,
  parameter int unsigned P_DATA_W     = 8,
  parameter int unsigned P_DELAY_UNIT = 25000,
  parameter int unsigned P_MAX_RETRY  = 3,
  // Default table is all end markers; integrators pass their sensor table.
  parameter logic [P_NUM_REGS*(P_ADDR_W+P_DATA_W)-1:0] P_ROM_DATA = '1,
  localparam int unsigned IDX_W = sccb_idx_width(P_NUM_REGS)
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  sccb_config_seq_if.master  sccb,
  output logic               o_fBusy,
  output logic               o_fDone,
  output logic               o_fErr,
  output logic [IDX_W-1:0]   o_Err_Idx
);

  localparam int unsigned ENTRY_W = P_ADDR_W + P_DATA_W;
  localparam int unsigned RETRY_W = sccb_idx_width(P_MAX_RETRY + 1);
  localparam int unsigned CNT_W   = sccb_cnt_width(P_DATA_W, P_DELAY_UNIT);

  localparam logic [P_ADDR_W-1:0] MARK_ADDR = P_ADDR_W'(SCCB_MARK_ADDR);
  localparam logic [P_DATA_W-1:0] END_VALUE = P_DATA_W'(SCCB_END_VALUE);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(P_NUM_REGS - 1);

  sccb_state_e         state_q,   state_d;
  logic [IDX_W-1:0]    index_q,   index_d;
  logic [RETRY_W-1:0]  retry_q,   retry_d;
  logic [CNT_W-1:0]    dly_q,     dly_d;
  logic                fstart_q,  fstart_d;
  logic [P_ADDR_W-1:0] addr_q,    addr_d;
  logic [P_DATA_W-1:0] value_q,   value_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                err_q,     err_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;
  logic                advance_c;

  logic [ENTRY_W-1:0]  rom_entry;
  logic [P_ADDR_W-1:0] rom_addr;
  logic [P_DATA_W-1:0] rom_value;

  sccb_config_rom #(
    .P_NUM_REGS (P_NUM_REGS),
    .P_ADDR_W   (P_ADDR_W),
    .P_DATA_W   (P_DATA_W),
    .P_ROM_DATA (P_ROM_DATA)
  ) u_rom (
    .i_Clk   (i_Clk),
    .i_Idx   (index_q),
    .o_Entry (rom_entry)
  );

  assign rom_addr  = rom_entry[ENTRY_W-1 -: P_ADDR_W];
  assign rom_value = rom_entry[P_DATA_W-1:0];

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      retry_q   <= '0;
      dly_q     <= '0;
      fstart_q  <= 1'b0;
      addr_q    <= '0;
      value_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      retry_q   <= retry_d;
      dly_q     <= dly_d;
      fstart_q  <= fstart_d;
      addr_q    <= addr_d;
      value_q   <= value_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Next-state and datapath: walk the table, one write or delay per entry.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    retry_d   = retry_q;
    dly_d     = dly_q;
    fstart_d  = 1'b0;
    addr_d    = addr_q;
    value_d   = value_q;
    err_idx_d = err_idx_q;
    advance_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        index_d = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (rom_addr == MARK_ADDR && rom_value == END_VALUE) begin
          state_d = S_DONE;
        end else if (rom_addr == MARK_ADDR) begin
          dly_d   = CNT_W'(rom_value) * CNT_W'(P_DELAY_UNIT);
          state_d = S_DELAY;
        end else begin
          addr_d  = rom_addr;
          value_d = rom_value;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sccb.SCCB_fReady) begin
          fstart_d = 1'b1;
          state_d  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!sccb.SCCB_fReady) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sccb.SCCB_fReady) begin
          if (!sccb.SCCB_fNack) begin
            retry_d   = '0;
            advance_c = 1'b1;
          end else if (retry_q < RETRY_W'(P_MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_ISSUE;
          end else begin
            err_idx_d = index_q;
            state_d   = S_FAIL;
          end
        end
      end
      S_DELAY: begin
        if (dly_q == '0) advance_c = 1'b1;
        else             dly_d     = dly_q - CNT_W'(1);
      end
      S_DONE, S_FAIL: begin
        if (i_Start) begin
          index_d   = '0;
          retry_d   = '0;
          err_idx_d = '0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Move to the next entry; running off the table end counts as completion.
    if (advance_c) begin
      if (index_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        index_d = index_q + IDX_W'(1);
        state_d = S_FETCH;
      end
    end

    busy_d = !(state_d == S_DONE || state_d == S_FAIL);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_FAIL);
  end

  assign sccb.SCCB_fStart  = fstart_q;
  assign sccb.SCCB_Address = addr_q;
  assign sccb.SCCB_Value   = value_q;
  assign o_fBusy           = busy_q;
  assign o_fDone           = done_q;
  assign o_fErr            = err_q;
  assign o_Err_Idx         = err_idx_q;

endmodule

// File: tb/tb_sccb_config_seq.sv
// Scoreboard bench for sccb_config_seq: a reference model expands the table
// into the expected write list, a monitor pops and compares on every fStart.
module tb_sccb_config_seq;

  localparam int MAX_RETRY = 3;
  localparam logic [127:0] ROM_A = {16'h6677, 16'h55AA, 16'hFF00, 16'h4010,
                                    16'hFF02, 16'h3A04, 16'h1101, 16'h1280};
  localparam logic [47:0]  ROM_B = {16'hFFFF, 16'h1101, 16'h1280};

  typedef struct packed { logic [7:0] a; logic [7:0] v; } wr_t;

  logic clk = 1'b0;
  logic rst_n, rst_b, start, start_b;
  logic busy, done, err;
  logic [2:0] err_idx;
  logic busy_b, done_b, err_b;
  logic [1:0] err_idx_b;

  logic slv_ready = 1'b1, slv_nack = 1'b0, hold_low, slow, cur_nack = 1'b0;
  logic rdy_b = 1'b1;
  logic [7:0] nack_addr;
  int nack_cnt, nack_seen = 0, run_gen, seen_gen = -1, busy_left = 0, cnt_b = 0;
  int cyc = 0, rise_cyc = 0, writes_seen = 0, nb = 0;
  int gap_plain = 0, gap_dly2 = 0, gap_dly0 = 0;
  int n_vec = 0, n_err = 0;
  wr_t exp_q[$];
  wr_t qb[$];

  sccb_config_seq_if #(.P_ADDR_W(8), .P_DATA_W(8)) sif ();
  sccb_config_seq_if #(.P_ADDR_W(8), .P_DATA_W(8)) sifb ();

  assign sif.SCCB_fReady  = slv_ready && !hold_low;
  assign sif.SCCB_fNack   = slv_nack;
  assign sifb.SCCB_fReady = rdy_b;
  assign sifb.SCCB_fNack  = 1'b0;

  sccb_config_seq #(
    .P_NUM_REGS(8), .P_ADDR_W(8), .P_DATA_W(8), .P_DELAY_UNIT(10),
    .P_MAX_RETRY(MAX_RETRY), .P_ROM_DATA(ROM_A)
  ) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_Start(start), .sccb(sif),
    .o_fBusy(busy), .o_fDone(done), .o_fErr(err), .o_Err_Idx(err_idx)
  );

  sccb_config_seq #(
    .P_NUM_REGS(3), .P_ADDR_W(8), .P_DATA_W(8), .P_DELAY_UNIT(10),
    .P_MAX_RETRY(MAX_RETRY), .P_ROM_DATA(ROM_B)
  ) dut_b (
    .i_Clk(clk), .i_Rst(rst_b), .i_Start(start_b), .sccb(sifb),
    .o_fBusy(busy_b), .o_fDone(done_b), .o_fErr(err_b), .o_Err_Idx(err_idx_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expand the table into writes under a NACK scenario.
  task automatic push_run(input logic [7:0] na, input int nc,
                          output bit fail, output int fidx);
    logic [127:0] rom;
    int n;
    rom = ROM_A; fail = 1'b0; fidx = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, v;
      a = rom[i*16+8 +: 8];
      v = rom[i*16 +: 8];
      if (a == 8'hFF) begin
        if (v == 8'hFF) return;
        continue;
      end
      n = (a == na) ? nc : 0;
      if (n > MAX_RETRY) begin
        repeat (MAX_RETRY + 1) exp_q.push_back('{a: a, v: v});
        fail = 1'b1; fidx = i;
        return;
      end
      repeat (n + 1) exp_q.push_back('{a: a, v: v});
    end
  endtask

  // SCCB slave model for the main DUT: random busy time, scripted NACKs.
  always @(negedge clk) begin
    if (!rst_n) begin
      slv_ready = 1'b1; slv_nack = 1'b0; busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        slv_ready = 1'b1; slv_nack = cur_nack; rise_cyc = cyc;
      end
    end else if (sif.SCCB_fStart) begin
      if (run_gen != seen_gen) begin seen_gen = run_gen; nack_seen = 0; end
      cur_nack = (sif.SCCB_Address == nack_addr) && (nack_seen < nack_cnt);
      if (cur_nack) nack_seen++;
      slv_ready = 1'b0;
      busy_left = slow ? 20 : int'($urandom_range(1, 6));
    end
  end

  // Always-ACK slave for the small-table DUT.
  always @(negedge clk) begin
    if (!rst_b) begin
      rdy_b = 1'b1; cnt_b = 0;
    end else if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0) rdy_b = 1'b1;
    end else if (sifb.SCCB_fStart) begin
      rdy_b = 1'b0; cnt_b = 2;
    end
  end

  // Monitor: each fStart pops one expected write.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (rst_n && sif.SCCB_fStart) begin
      writes_seen++;
      if (sif.SCCB_Address == 8'h3A) gap_plain = cyc - rise_cyc;
      if (sif.SCCB_Address == 8'h40) gap_dly2  = cyc - rise_cyc;
      if (sif.SCCB_Address == 8'h55) gap_dly0  = cyc - rise_cyc;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL extra_write: got %0h/%0h expected none",
                 sif.SCCB_Address, sif.SCCB_Value);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", sif.SCCB_Address, e.a);
        chk("wr_value", sif.SCCB_Value, e.v);
      end
    end
  end

  initial forever begin
    wr_t e;
    @(negedge clk);
    if (rst_b && sifb.SCCB_fStart) begin
      nb++;
      if (qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_extra_write: got %0h expected none", sifb.SCCB_Address);
      end else begin
        e = qb.pop_front();
        chk("b_wr_addr", sifb.SCCB_Address, e.a);
        chk("b_wr_value", sifb.SCCB_Value, e.v);
      end
    end
  end

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Wait for the sequence to settle, then compare status against the model.
  task automatic finish_run(input bit fail, input int fidx);
    for (int k = 0; k < 20000 && busy; k++) @(negedge clk);
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: busy=%0b expected 0", busy);
    end
    chk("done", done, !fail);
    chk("err", err, fail);
    if (fail) chk("err_idx", err_idx, fidx);
    chk("busy_end", busy, 0);
    chk("writes_left", exp_q.size(), 0);
  endtask

  initial begin
    bit f;
    int fi, base;
    logic [7:0] addrs [6];
    addrs = '{8'h12, 8'h11, 8'h3A, 8'h40, 8'h55, 8'h66};
    rst_n = 1'b0; rst_b = 1'b0; start = 1'b0; start_b = 1'b0;
    hold_low = 1'b1; slow = 1'b0; nack_addr = 8'h00; nack_cnt = 0; run_gen = 0;
    qb.push_back('{a: 8'h12, v: 8'h80});
    qb.push_back('{a: 8'h11, v: 8'h01});
    push_run(8'h00, 0, f, fi);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_err", err, 0);       chk("rst_idx", err_idx, 0);
    chk("rst_fstart", sif.SCCB_fStart, 0);
    chk("rst_addr", sif.SCCB_Address, 0);
    chk("rst_value", sif.SCCB_Value, 0);

    // Run 1: ready held low for 500 cycles, i_Start pulsed while busy.
    @(negedge clk); rst_n = 1'b1; rst_b = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (300) @(negedge clk);
    chk("hold_no_write", writes_seen, 0);
    chk("hold_busy", busy, 1);
    hold_low = 1'b0;
    finish_run(f, fi);

    // Run 2: plain all-ACK restart; also check delay entry timing.
    run_gen++;
    push_run(8'h00, 0, f, fi);
    pulse_start;
    finish_run(f, fi);
    n_vec++;
    if (gap_dly2 - gap_dly0 < 19 || gap_dly2 - gap_dly0 > 21) begin
      n_err++;
      $display("FAIL delay_gap: got %0d expected 20+/-1", gap_dly2 - gap_dly0);
    end
    n_vec++;
    if (gap_dly0 <= gap_plain) begin
      n_err++;
      $display("FAIL zero_delay_cost: got %0d expected > %0d", gap_dly0, gap_plain);
    end

    // Run 3: two NACKs on entry 1, then ACK.
    run_gen++; nack_addr = 8'h11; nack_cnt = 2;
    push_run(nack_addr, nack_cnt, f, fi);
    pulse_start;
    finish_run(f, fi);

    // Run 4: permanent NACK on entry 4.
    run_gen++; nack_addr = 8'h40; nack_cnt = 99;
    push_run(nack_addr, nack_cnt, f, fi);
    pulse_start;
    finish_run(f, fi);

    // Randomized NACK scenarios.
    for (int r = 0; r < 6; r++) begin
      run_gen++;
      nack_addr = addrs[$urandom_range(0, 5)];
      nack_cnt  = int'($urandom_range(0, 5));
      push_run(nack_addr, nack_cnt, f, fi);
      pulse_start;
      finish_run(f, fi);
    end

    // Reset while entry 2's write is outstanding.
    run_gen++; nack_addr = 8'h00; nack_cnt = 0; slow = 1'b1;
    push_run(8'h00, 0, f, fi);
    base = writes_seen;
    pulse_start;
    for (int k = 0; k < 2000 && writes_seen < base + 3; k++) @(negedge clk);
    chk("reach_entry2", writes_seen - base, 3);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);  chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);    chk("mid_rst_idx", err_idx, 0);
    chk("mid_rst_fstart", sif.SCCB_fStart, 0);
    chk("mid_rst_addr", sif.SCCB_Address, 0);
    chk("mid_rst_value", sif.SCCB_Value, 0);
    exp_q.delete();
    slow = 1'b0;
    push_run(8'h00, 0, f, fi);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    finish_run(f, fi);

    // Small table with end marker.
    chk("b_writes", nb, 2);
    chk("b_done", done_b, 1);
    chk("b_busy", busy_b, 0);
    chk("b_err", err_b, 0);
    chk("b_err_idx", err_idx_b, 0);
    chk("b_left", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
